alu_seq: RTL and testbench

Parametrised, handshaked successor to the 32-bit single-cycle ALU used in the datapath.
- Keeps the existing op encodings and adds shifts, plus iterative multiply and unsigned divide/remainder.
- Results and flags are registered and presented on a valid/ready output channel.
- Sits between the decode/issue stage and writeback; the execute stage stalls on in_ready/out_valid.

---
 rtl/alu_seq.sv | 130 +++++++++++++
 tb/tb_alu_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith/shift ops and iterative multiply/divide.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             bad_op
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SLL = 4'b0011,
                         OP_SRL = 4'b0100, OP_SRA = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111,
                         OP_MUL = 4'b1000, OP_DIVU = 4'b1001, OP_REMU = 4'b1010, OP_NOR = 4'b1100,
                         OP_EQ = 4'b1111;
  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [3:0]       opr;
  logic [WIDTH-1:0] x, y, acc;
  logic [WIDTH:0]   sum, dif, d_r, d_s;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] s_res, m_acc, d_rem, d_quo;
  logic             s_c, s_v, s_bad, iter, d_ge;
  assign sum = {1'b0, a_in} + {1'b0, b_in};
  assign dif = {1'b0, a_in} - {1'b0, b_in};
  assign sh = b_in[SHW-1:0];
  assign iter = (op == OP_MUL) || ((op == OP_DIVU || op == OP_REMU) && |b_in);
  always_comb begin
    s_res = '0;
    s_c = 1'b0;
    s_v = 1'b0;
    s_bad = 1'b0;
    case (op)
      OP_AND: s_res = a_in & b_in;
      OP_OR:  s_res = a_in | b_in;
      OP_NOR: s_res = ~(a_in | b_in);
      OP_ADD: begin
        s_res = sum[WIDTH-1:0];
        s_c = sum[WIDTH];
        s_v = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = dif[WIDTH-1:0];
        s_c = ~dif[WIDTH];
        s_v = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (dif[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      OP_EQ:   s_res = {{(WIDTH-1){1'b0}}, a_in == b_in};
      OP_SLL:  s_res = a_in << sh;
      OP_SRL:  s_res = a_in >> sh;
      OP_SRA:  s_res = $unsigned($signed(a_in) >>> sh);
      OP_MUL:  s_res = '0;
      // reached only for divide by zero; nonzero divisors take the iterative path
      OP_DIVU: s_res = '1;
      OP_REMU: s_res = a_in;
      default: s_bad = 1'b1;
    endcase
  end
  assign m_acc = acc + (y[0] ? x : '0);
  assign d_r = {acc, x[WIDTH-1]};
  assign d_s = d_r - {1'b0, y};
  assign d_ge = ~d_s[WIDTH];
  assign d_rem = d_ge ? d_s[WIDTH-1:0] : d_r[WIDTH-1:0];
  assign d_quo = {x[WIDTH-2:0], d_ge};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      opr <= '0;
      x <= '0;
      y <= '0;
      acc <= '0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      bad_op <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opr <= op;
          x <= a_in;
          y <= b_in;
          acc <= '0;
          cnt <= SHW'(WIDTH - 1);
          if (iter) state <= BUSY;
          else begin
            state <= DONE;
            result <= s_res;
            carry_out <= s_c;
            overflow <= s_v;
            bad_op <= s_bad;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (opr == OP_MUL) begin
            acc <= m_acc;
            x <= x << 1;
            y <= y >> 1;
          end else begin
            acc <= d_rem;
            x <= d_quo;
          end
          if (cnt == '0) begin
            state <= DONE;
            result <= (opr == OP_MUL) ? m_acc : (opr == OP_DIVU) ? d_quo : d_rem;
            carry_out <= 1'b0;
            overflow <= 1'b0;
            bad_op <= 1'b0;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero = (result == '0);
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;
  logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
  always #5 clk = ~clk;
  logic iv[2], ordy[2];
  logic [3:0] opi[2];
  logic [31:0] ai[2], bi[2];
  logic ir0, ov0, c0, v0, z0, b0, ir1, ov1, c1, v1, z1, b1;
  logic [31:0] r0;
  logic [7:0] r1;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [31:0] r; logic c, v, b; int lat, e;} exp_t;
  exp_t q0[$], q1[$];

  alu_seq #(.WIDTH(32)) dut0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .op(opi[0]),
    .a_in(ai[0]), .b_in(bi[0]), .out_valid(ov0), .out_ready(ordy[0]), .result(r0),
    .carry_out(c0), .overflow(v0), .zero(z0), .bad_op(b0));
  alu_seq #(.WIDTH(8)) dut1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .op(opi[1]),
    .a_in(ai[1][7:0]), .b_in(bi[1][7:0]), .out_valid(ov1), .out_ready(ordy[1]), .result(r1),
    .carry_out(c1), .overflow(v1), .zero(z1), .bad_op(b1));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference: plain arithmetic on w-bit values, signed view derived from the unsigned value
  function automatic exp_t model(input int w, input logic [3:0] op, input logic [31:0] a32,
                                 input logic [31:0] b32, input int e);
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned a = {32'd0, a32} & m;
    longint unsigned b = {32'd0, b32} & m;
    longint unsigned s;
    longint smax = longint'(m >> 1);
    longint sa = (a > m >> 1) ? longint'(a) - longint'(m) - 1 : longint'(a);
    longint sb = (b > m >> 1) ? longint'(b) - longint'(m) - 1 : longint'(b);
    int sh = int'(b % longint'(w));
    exp_t x = '{r: 0, c: 0, v: 0, b: 0, lat: 0, e: e};
    case (op)
      4'd0: s = a & b;
      4'd1: s = a | b;
      4'd12: s = ~(a | b);
      4'd2: begin s = a + b; x.c = s > m; x.v = (sa + sb > smax) || (sa + sb < -smax - 1); end
      4'd6: begin s = a - b; x.c = a >= b; x.v = (sa - sb > smax) || (sa - sb < -smax - 1); end
      4'd7: s = {63'd0, sa < sb};
      4'd15: s = {63'd0, a == b};
      4'd3: s = a << sh;
      4'd4: s = a >> sh;
      4'd5: s = longint'(sa >>> sh);
      4'd8: begin s = a * b; x.lat = w; end
      4'd9: begin s = (b == 0) ? m : a / b; x.lat = (b == 0) ? 0 : w; end
      4'd10: begin s = (b == 0) ? a : a % b; x.lat = (b == 0) ? 0 : w; end
      default: begin s = 0; x.b = 1'b1; end
    endcase
    x.r = 32'(s & m);
    return x;
  endfunction

  task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    iv[d] = 1'b1; opi[d] = op; ai[d] = a; bi[d] = b;
    @(negedge clk);
    while (!(d ? ir1 : ir0) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL accept_timeout d%0d op=%h waited=%0d limit=500", d, op, n);
      iv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    if (d == 0) q0.push_back(model(32, op, a, b, cyc));
    else q1.push_back(model(8, op, a, b, cyc));
    #1;
    iv[d] = 1'b0; opi[d] = 4'($urandom); ai[d] = $urandom; bi[d] = $urandom;
  endtask

  task automatic rand_op(input int d);
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0: b = 0;
      1: b = $urandom_range(1, 40);
      default: b = $urandom;
    endcase
    issue(d, 4'($urandom_range(0, 15)), $urandom, b);
  endtask

  task automatic drain();
    int n = 0;
    while (q0.size() + q1.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d want=0", q0.size() + q1.size());
    end
  endtask

  initial begin
    ordy = '{1'b0, 1'b0};
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) ordy[d] = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    logic seen[2];
    exp_t cur[2];
    logic v, ir, c, o, z, bd;
    logic [31:0] r;
    seen = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      if (rst) begin seen = '{1'b0, 1'b0}; continue; end
      for (int d = 0; d < 2; d++) begin
        v = d ? ov1 : ov0; ir = d ? ir1 : ir0; c = d ? c1 : c0; o = d ? v1 : v0;
        z = d ? z1 : z0; bd = d ? b1 : b0; r = d ? {24'd0, r1} : r0;
        if (v && !seen[d]) begin
          if ((d ? q1.size() : q0.size()) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out d%0d result=%h want=no_output", d, r);
          end else begin
            cur[d] = d ? q1.pop_front() : q0.pop_front();
            seen[d] = 1'b1;
            chk(d ? "latency8" : "latency32", cyc - 1 - cur[d].e, cur[d].lat);
          end
        end
        if (v && seen[d]) begin
          chk(d ? "result8" : "result32", r, cur[d].r);
          chk("carry_out", c, cur[d].c);
          chk("overflow", o, cur[d].v);
          chk("bad_op", bd, cur[d].b);
          chk("zero", z, cur[d].r == 0);
          chk("in_ready_while_done", ir, 0);
          if (ordy[d]) seen[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    iv = '{1'b0, 1'b0}; opi = '{4'd0, 4'd0}; ai = '{0, 0}; bi = '{0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", ov0, 0); chk("rst_in_ready", ir0, 1); chk("rst_result", r0, 0);
    chk("rst_zero", z0, 1); chk("rst_flags", {c0, v0, b0}, 0);
    chk("rst8_out_valid", ov1, 0); chk("rst8_in_ready", ir1, 1); chk("rst8_result", r1, 0);
    chk("rst8_zero", z1, 1);
    issue(0, 4'b0010, 32'h7FFF_FFFF, 32'h1);
    issue(0, 4'b0010, 32'hFFFF_FFFF, 32'h1);
    issue(0, 4'b0110, 32'd5, 32'd7);
    issue(0, 4'b0111, 32'hFFFF_FFFE, 32'h1);
    issue(0, 4'b0101, 32'h8000_0000, 32'h24);
    hold = 1'b1;
    issue(0, 4'b1000, 32'h0001_0003, 32'h5);
    repeat (38) @(negedge clk);
    hold = 1'b0;
    issue(0, 4'b1001, 32'd100, 32'd7);
    issue(0, 4'b1010, 32'd100, 32'd7);
    issue(0, 4'b1001, 32'd9, 32'd0);
    issue(0, 4'b1010, 32'd9, 32'd0);
    issue(0, 4'b1011, $urandom, $urandom);
    issue(0, 4'b1000, $urandom, $urandom);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("midrst_out_valid", ov0, 0); chk("midrst_in_ready", ir0, 1);
    chk("midrst_result", r0, 0); chk("midrst_zero", z0, 1);
    issue(0, 4'b0010, 32'd1, 32'd1);
    for (int i = 0; i < 150; i++) rand_op(0);
    drain();
    issue(1, 4'b0010, 32'h7F, 32'h1);
    issue(1, 4'b1000, 32'h10, 32'h10);
    for (int i = 0; i < 80; i++) rand_op(1);
    drain();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
